// File: rtl/fb_write_arbiter.sv
// Write arbiter for the order-book display frame buffer: round-robin between the
// HPS register path (port 0) and the update engine (port 1), plus a clear sequencer.
module fb_write_arbiter #(
    parameter int unsigned       ROWS        = 10,
    parameter int unsigned       COLS        = 2,
    parameter int unsigned       DATA_W      = 6,
    parameter int unsigned       ROW_W       = 4,
    parameter int unsigned       COL_W       = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL   = '0,
    parameter bit                GATE_VBLANK = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ROW_W-1:0]  r0_row,
    input  logic [COL_W-1:0]  r0_col,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ROW_W-1:0]  r1_row,
    input  logic [COL_W-1:0]  r1_col,
    input  logic [DATA_W-1:0] r1_data,
    input  logic              clear_start,
    input  logic              vblank,
    output logic              fb_we,
    output logic [ROW_W-1:0]  fb_row,
    output logic [COL_W-1:0]  fb_col,
    output logic [DATA_W-1:0] fb_data,
    output logic              busy,
    output logic              addr_err
);

    localparam int unsigned ENTRIES = ROWS * COLS;
    localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              last_grant_q;
    logic              fb_we_q;
    logic [ROW_W-1:0]  fb_row_q;
    logic [COL_W-1:0]  fb_col_q;
    logic [DATA_W-1:0] fb_data_q;
    logic              busy_q;
    logic              addr_err_q;

    logic              can_accept;
    logic              grant1;
    logic              handshake;
    logic [ROW_W-1:0]  sel_row;
    logic [COL_W-1:0]  sel_col;
    logic [DATA_W-1:0] sel_data;
    logic              sel_in_range;
    logic [ROW_W-1:0]  clear_row;
    logic [COL_W-1:0]  clear_col;

    // A pending clear_start blocks acceptance in the same cycle so clear always wins.
    assign can_accept = reset_n && (state_q == IDLE) && !clear_start
                        && (!GATE_VBLANK || vblank);
    assign grant1     = r1_valid && (!r0_valid || !last_grant_q);
    assign r1_ready   = can_accept && grant1;
    assign r0_ready   = can_accept && r0_valid && !grant1;
    assign handshake  = r0_ready || r1_ready;

    assign sel_row      = grant1 ? r1_row  : r0_row;
    assign sel_col      = grant1 ? r1_col  : r0_col;
    assign sel_data     = grant1 ? r1_data : r0_data;
    assign sel_in_range = (32'(sel_row) < ROWS) && (32'(sel_col) < COLS);

    assign clear_row = ROW_W'(32'(idx_q) / COLS);
    assign clear_col = COL_W'(32'(idx_q) % COLS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_grant_q <= 1'b1;
            fb_we_q      <= 1'b0;
            fb_row_q     <= '0;
            fb_col_q     <= '0;
            fb_data_q    <= '0;
            busy_q       <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            fb_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        state_q    <= CLEAR;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        addr_err_q <= 1'b0;
                    end else if (handshake) begin
                        last_grant_q <= grant1;
                        // Out-of-range requests are consumed but never reach the buffer.
                        if (sel_in_range) begin
                            fb_we_q   <= 1'b1;
                            fb_row_q  <= sel_row;
                            fb_col_q  <= sel_col;
                            fb_data_q <= sel_data;
                        end else begin
                            addr_err_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    fb_we_q   <= 1'b1;
                    fb_row_q  <= clear_row;
                    fb_col_q  <= clear_col;
                    fb_data_q <= CLEAR_VAL;
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_row   = fb_row_q;
    assign fb_col   = fb_col_q;
    assign fb_data  = fb_data_q;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the frame-buffer writer.
module tb_fb_write_arbiter;

    localparam int ROWS = 10;
    localparam int COLS = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [3:0] r0_row, r1_row;
    logic [0:0] r0_col, r1_col;
    logic [5:0] r0_data, r1_data;
    logic       clear_start, vblank;
    logic       fb_we, busy, addr_err;
    logic [3:0] fb_row;
    logic [0:0] fb_col;
    logic [5:0] fb_data;

    fb_write_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_row(r0_row), .r0_col(r0_col), .r0_data(r0_data),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_row(r1_row), .r1_col(r1_col), .r1_data(r1_data),
        .clear_start(clear_start), .vblank(vblank),
        .fb_we(fb_we), .fb_row(fb_row), .fb_col(fb_col), .fb_data(fb_data),
        .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: clear_left counts remaining clear writes, last is the last granted port.
    int m_clear_left, m_idx, m_last, m_row, m_col, m_data;
    bit m_we, m_busy, m_err;
    bit e_r0, e_r1, hs0, hs1;
    int n0 = 0, n1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clear_left = 0; m_idx = 0; m_last = 1;
        m_we = 0; m_row = 0; m_col = 0; m_data = 0;
        m_busy = 0; m_err = 0;
    endtask

    // Called just after a falling edge with inputs settled; returns after the next falling edge.
    task automatic cycle();
        bit ok;
        ok   = reset_n && (m_clear_left == 0) && !clear_start && vblank;
        e_r0 = ok && r0_valid && (!r1_valid || m_last == 1);
        e_r1 = ok && r1_valid && (!r0_valid || m_last == 0);
        #1;
        chk("r0_ready", 32'(r0_ready), 32'(e_r0));
        chk("r1_ready", 32'(r1_ready), 32'(e_r1));
        hs0 = e_r0; hs1 = e_r1;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else if (m_clear_left > 0) begin
            m_we = 1; m_row = m_idx / COLS; m_col = m_idx % COLS; m_data = 0;
            m_idx++; m_clear_left--;
            m_busy = (m_clear_left > 0);
        end else if (clear_start) begin
            m_clear_left = ROWS * COLS; m_idx = 0; m_busy = 1; m_err = 0; m_we = 0;
        end else if (hs0 || hs1) begin
            int row, col, data;
            row  = hs0 ? int'(r0_row)  : int'(r1_row);
            col  = hs0 ? int'(r0_col)  : int'(r1_col);
            data = hs0 ? int'(r0_data) : int'(r1_data);
            m_last = hs0 ? 0 : 1;
            if (row < ROWS && col < COLS) begin
                m_we = 1; m_row = row; m_col = col; m_data = data;
            end else begin
                m_we = 0; m_err = 1;
            end
        end else begin
            m_we = 0;
        end
        #1;
        chk("fb_we", 32'(fb_we), 32'(m_we));
        chk("fb_row", 32'(fb_row), 32'(m_row));
        chk("fb_col", 32'(fb_col), 32'(m_col));
        chk("fb_data", 32'(fb_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("addr_err", 32'(addr_err), 32'(m_err));
        @(negedge clk);
        if (hs0) begin r0_valid = 0; n0++; end
        if (hs1) begin r1_valid = 0; n1++; end
    endtask

    initial begin
        reset_n = 0; r0_valid = 0; r1_valid = 0; clear_start = 0; vblank = 0;
        r0_row = 0; r0_col = 0; r0_data = 0; r1_row = 0; r1_col = 0; r1_data = 0;
        model_reset();
        @(negedge clk);
        cycle();
        chk("reset_fb_we", 32'(fb_we), 0);
        chk("reset_busy", 32'(busy), 0);
        reset_n = 1;

        // Contention: port 0 wins the first tie after reset, then strict alternation.
        for (int k = 0; k < 4; k++) begin
            vblank = 1;
            r0_valid = 1; r0_row = 4'(n0); r0_col = 0; r0_data = 6'(8 + n0);
            r1_valid = 1; r1_row = 4'(n1 + 5); r1_col = 1; r1_data = 6'(40 + n1);
            #1;
            chk("cont_gnt0", 32'(r0_ready), 32'(k % 2 == 0));
            chk("cont_gnt1", 32'(r1_ready), 32'(k % 2 == 1));
            cycle();
            chk("cont_we", 32'(fb_we), 1);
        end
        r0_valid = 0; r1_valid = 0;
        cycle();

        // Single write on port 1.
        r1_valid = 1; r1_row = 3; r1_col = 1; r1_data = 42; vblank = 1;
        #1 chk("single_ready", 32'(r1_ready), 1);
        cycle();
        chk("single_we", 32'(fb_we), 1);
        chk("single_row", 32'(fb_row), 3);
        chk("single_col", 32'(fb_col), 1);
        chk("single_data", 32'(fb_data), 42);
        cycle();
        chk("single_we_drop", 32'(fb_we), 0);

        // Vblank gating.
        r0_valid = 1; r0_row = 5; r0_col = 0; r0_data = 7; vblank = 0;
        for (int k = 0; k < 10; k++) begin
            #1 chk("gate_ready", 32'(r0_ready), 0);
            cycle();
            chk("gate_we", 32'(fb_we), 0);
        end
        vblank = 1;
        #1 chk("gate_accept", 32'(r0_ready), 1);
        cycle();
        chk("gate_data", 32'(fb_data), 7);

        // Clear with a pending request; a second clear_start mid-sequence is ignored.
        r0_valid = 1; r0_row = 4; r0_col = 1; r0_data = 9; clear_start = 1;
        #1 chk("clr_block", 32'(r0_ready), 0);
        cycle();
        clear_start = 0;
        chk("clr_busy_rise", 32'(busy), 1);
        for (int i = 1; i <= 20; i++) begin
            clear_start = (i == 6);
            cycle();
            chk("clr_we", 32'(fb_we), 1);
            chk("clr_row", 32'(fb_row), 32'((i - 1) / 2));
            chk("clr_col", 32'(fb_col), 32'((i - 1) % 2));
            chk("clr_busy", 32'(busy), 32'(i < 20));
        end
        clear_start = 0;
        #1 chk("clr_release", 32'(r0_ready), 1);
        cycle();
        chk("clr_pending_data", 32'(fb_data), 9);

        // Address error: consumed, no write, sticky until a clear.
        r0_valid = 1; r0_row = 12; r0_col = 0; r0_data = 5;
        #1 chk("aerr_ready", 32'(r0_ready), 1);
        cycle();
        chk("aerr_we", 32'(fb_we), 0);
        chk("aerr_set", 32'(addr_err), 1);
        repeat (3) cycle();
        chk("aerr_sticky", 32'(addr_err), 1);
        clear_start = 1;
        cycle();
        clear_start = 0;
        chk("aerr_clear", 32'(addr_err), 0);
        while (m_idx < 7) cycle();

        // Asynchronous reset mid-clear.
        reset_n = 0; r0_valid = 1; r0_row = 2; r0_col = 0; r0_data = 17; vblank = 1;
        #1;
        chk("arst_we", 32'(fb_we), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(r0_ready), 0);
        model_reset();
        @(negedge clk);
        cycle();
        reset_n = 1;
        #1 chk("arst_idle_ready", 32'(r0_ready), 1);
        cycle();

        // Random traffic; a requester holds its request until it is accepted.
        for (int k = 0; k < 3000; k++) begin
            if (!r0_valid && $urandom_range(0, 9) < 6) begin
                r0_valid = 1; r0_row = 4'($urandom_range(0, 11));
                r0_col = 1'($urandom_range(0, 1)); r0_data = 6'($urandom);
            end
            if (!r1_valid && $urandom_range(0, 9) < 6) begin
                r1_valid = 1; r1_row = 4'($urandom_range(0, 11));
                r1_col = 1'($urandom_range(0, 1)); r1_data = 6'($urandom);
            end
            vblank = ($urandom_range(0, 3) != 0);
            clear_start = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
